// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half_adder slice.
// Used by half_adder with or without HALF_ADDER_STATS_EN.
package half_adder_pkg;

  localparam int HA_WIDTH_DEF = 1;
  localparam int HA_CNT_W_DEF = 16;

  // Widest lane vector ha_popcount can take; narrower vectors are zero-extended.
  localparam int HA_POP_MAX = 1024;

  function automatic int ha_cnt_w(input int width);
    int w;
    w = $clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned ha_popcount(input logic [HA_POP_MAX-1:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < HA_POP_MAX; i++) begin
      n += {31'b0, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/half_adder_lane.sv
// Combinational 1-bit half-adder cell: sum = a ^ b, cout = a & b.
module half_adder_lane (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered, lane-parallel half adder with carry summary flags.
// Optional statistics counters are built when HALF_ADDER_STATS_EN is defined.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH_DEF,
  parameter int CNT_W = HA_CNT_W_DEF,
  localparam int CW   = ha_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic             carry_any,
  output logic [CW-1:0]    carry_cnt
`ifdef HALF_ADDER_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] carry_ev_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > HA_POP_MAX) begin : g_bad_width
    $error("half_adder: WIDTH out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("half_adder: CNT_W must be >= 1");
  end

  logic [WIDTH-1:0]      sum_nxt;
  logic [WIDTH-1:0]      cout_nxt;
  logic [HA_POP_MAX-1:0] cout_ext;
  logic [CW-1:0]         cnt_nxt;
  logic                  any_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .a    (a[i]),
      .b    (b[i]),
      .sum  (sum_nxt[i]),
      .cout (cout_nxt[i])
    );
  end

  assign cout_ext = HA_POP_MAX'(cout_nxt);
  assign cnt_nxt  = CW'(ha_popcount(cout_ext));
  assign any_nxt  = |cout_nxt;

  // Data registers load only on in_valid, so X on idle inputs never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= '0;
      carry_any <= 1'b0;
      carry_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_nxt;
        cout      <= cout_nxt;
        carry_any <= any_nxt;
        carry_cnt <= cnt_nxt;
      end
    end
  end

`ifdef HALF_ADDER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Clear wins over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt       <= '0;
      carry_ev_cnt <= '0;
    end else if (stats_clr) begin
      op_cnt       <= '0;
      carry_ev_cnt <= '0;
    end else if (in_valid) begin
      if (op_cnt != CNT_MAX) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
      if (any_nxt && (carry_ev_cnt != CNT_MAX)) begin
        carry_ev_cnt <= carry_ev_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: a WIDTH=1 and a WIDTH=8 (CNT_W=4) instance.
// Statistics checks are compiled in when HALF_ADDER_STATS_EN is defined.
module tb_half_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       iv1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ov1, any1;
  logic [0:0] s1, c1, cnt1;

  logic       iv8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8, any8;
  logic [7:0] s8, c8;
  logic [3:0] cnt8;

`ifdef HALF_ADDER_STATS_EN
  logic        clr1 = 1'b0, clr8 = 1'b0;
  logic [15:0] op1, ev1;
  logic [3:0]  op8, ev8;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic ea, eb;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1),
    .out_valid(ov1), .sum(s1), .cout(c1), .carry_any(any1), .carry_cnt(cnt1)
`ifdef HALF_ADDER_STATS_EN
    , .stats_clr(clr1), .op_cnt(op1), .carry_ev_cnt(ev1)
`endif
  );

  half_adder #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8),
    .out_valid(ov8), .sum(s8), .cout(c8), .carry_any(any8), .carry_cnt(cnt8)
`ifdef HALF_ADDER_STATS_EN
    , .stats_clr(clr8), .op_cnt(op8), .carry_ev_cnt(ev8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one lane-1 operation at a negedge, check its result at the next negedge.
  task automatic op1_chk(input logic ai, input logic bi,
                         input logic es, input logic ec, input logic eany);
    a1 = ai; b1 = bi; iv1 = 1'b1;
    @(negedge clk);
    chk("w1_valid", {31'b0, ov1}, 32'd1);
    chk("w1_sum",   {31'b0, s1},  {31'b0, es});
    chk("w1_cout",  {31'b0, c1},  {31'b0, ec});
    chk("w1_any",   {31'b0, any1}, {31'b0, eany});
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ov1",  {31'b0, ov1}, 32'd0);
    chk("rst_s1",   {31'b0, s1},  32'd0);
    chk("rst_c1",   {31'b0, c1},  32'd0);
    chk("rst_ov8",  {31'b0, ov8}, 32'd0);
    chk("rst_cnt8", {28'b0, cnt8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=1 truth table, back to back
    op1_chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op1_chk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    op1_chk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    op1_chk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("w1_cnt_11", {31'b0, cnt1}, 32'd1);

    // Free-running toggle: a every 10 ns, b every 15 ns, offset 2 ns from posedge
    a1 = 1'b0; b1 = 1'b0; iv1 = 1'b1;
    @(posedge clk);
    #2;
    fork
      begin
        for (int k = 0; k < 22; k++) begin
          if (k % 2 == 0) a1 = ~a1;
          if (k % 3 == 0) b1 = ~b1;
          #5;
        end
      end
    join_none
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      ea = a1[0]; eb = b1[0];
      #1;
      chk("tog_sum",  {31'b0, s1},  {31'b0, ea ^ eb});
      chk("tog_cout", {31'b0, c1},  {31'b0, ea & eb});
      chk("tog_ov",   {31'b0, ov1}, 32'd1);
    end
    @(negedge clk);

    // WIDTH=8 vectors
    a8 = 8'hF0; b8 = 8'hCC; iv8 = 1'b1;
    @(negedge clk);
    chk("w8_sum_a",  {24'b0, s8},   32'h3C);
    chk("w8_cout_a", {24'b0, c8},   32'hC0);
    chk("w8_cnt_a",  {28'b0, cnt8}, 32'd2);
    chk("w8_any_a",  {31'b0, any8}, 32'd1);
    a8 = 8'h0F; b8 = 8'h30;
    @(negedge clk);
    chk("w8_sum_b",  {24'b0, s8},   32'h3F);
    chk("w8_cout_b", {24'b0, c8},   32'h00);
    chk("w8_cnt_b",  {28'b0, cnt8}, 32'd0);
    chk("w8_any_b",  {31'b0, any8}, 32'd0);

    // Fresh lane-1 result (a=b=1), then hold with X on idle inputs
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    a8 = 8'hFF; b8 = 8'h81;
    @(negedge clk);
    chk("w8_cnt_c", {28'b0, cnt8}, 32'd2);
    iv1 = 1'b0; iv8 = 1'b0;
    a1 = 'x; b1 = 'x; a8 = 'x; b8 = 'x;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("hold_ov1", {31'b0, ov1}, 32'd0);
      chk("hold_s1",  {31'b0, s1},  32'd0);
      chk("hold_c1",  {31'b0, c1},  32'd1);
      chk("hold_ov8", {31'b0, ov8}, 32'd0);
      chk("hold_s8",  {24'b0, s8},  32'h7E);
      chk("hold_c8",  {24'b0, c8},  32'h81);
    end

    // Asynchronous reset between edges, with a pending result in flight
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ov1",  {31'b0, ov1},  32'd0);
    chk("arst_c1",   {31'b0, c1},   32'd0);
    chk("arst_any1", {31'b0, any1}, 32'd0);
    chk("arst_ov8",  {31'b0, ov8},  32'd0);
    chk("arst_c8",   {24'b0, c8},   32'd0);
    chk("arst_cnt8", {28'b0, cnt8}, 32'd0);
    iv1 = 1'b0; iv8 = 1'b0;
    a1 = '0; b1 = '0; a8 = '0; b8 = '0;
    @(negedge clk);
    chk("arst_hold_ov1", {31'b0, ov1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef HALF_ADDER_STATS_EN
    chk("st_rst_op8", {28'b0, op8}, 32'd0);
    chk("st_rst_ev8", {28'b0, ev8}, 32'd0);
    a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 5) begin
        chk("st_op8_5", {28'b0, op8}, 32'd5);
        chk("st_ev8_5", {28'b0, ev8}, 32'd5);
      end
    end
    chk("st_op8_sat", {28'b0, op8}, 32'd15);
    chk("st_ev8_sat", {28'b0, ev8}, 32'd15);
    clr8 = 1'b1;
    @(negedge clk);
    chk("st_clr_op8", {28'b0, op8}, 32'd0);
    chk("st_clr_ev8", {28'b0, ev8}, 32'd0);
    clr8 = 1'b0;
    a8 = 8'h0F; b8 = 8'h30;
    @(negedge clk);
    chk("st_nc_op8", {28'b0, op8}, 32'd1);
    chk("st_nc_ev8", {28'b0, ev8}, 32'd0);
    iv8 = 1'b0;
    a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
    @(negedge clk);
    chk("st_op1", {16'b0, op1}, 32'd1);
    chk("st_ev1", {16'b0, ev1}, 32'd0);
    iv1 = 1'b0;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
